mem_port_arbiter: RTL

Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the 5-stage RV32I pipeline. The MEM stage has fixed priority over IF. The block sequences each access through a request/ready handshake toward memory, drives per-stage acks and stall lines consumed by the hazard logic, and aborts accesses that exceed a latency bound. It sits between the pipeline stage registers and the memory model, downstream of the control unit's `load`/`store` decode.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and the MEM stage. Data accesses have fixed priority. Each access is
// registered onto the memory bus, completed by mem_ready or aborted after a
// bounded number of wait cycles, and acknowledged for exactly one cycle.
//
// Handshake: the arbiter presents a request with mem_valid=1 and keeps every
// mem_* field stable until the cycle in which mem_ready=1 (or the timeout
// fires); that cycle completes the access, the requester sees x_ack=1 in the
// same cycle, and mem_valid drops on the following edge. Requesters hold
// x_req and their request fields stable until they see x_ack=1.
module mem_port_arbiter #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [31:0]          if_addr,
    output logic [31:0]          if_rdata,
    output logic                 if_ack,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [3:0]           dm_mask,
    input  logic [31:0]          dm_addr,
    input  logic [31:0]          dm_wdata,
    output logic [31:0]          dm_rdata,
    output logic                 dm_ack,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [3:0]           mem_mask,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic                 bus_err,
    output logic                 stall_if,
    output logic                 stall_mem,
    input  logic                 perf_clr,
    output logic [CNT_WIDTH-1:0] conflict_cnt,
    output logic [1:0]           dbg_state
);

    // Timeout counter only needs to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_mem_valid;
    logic                  r_mem_we;
    logic [3:0]            r_mem_mask;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [TW-1:0]         r_tmo_cnt;
    logic [CNT_WIDTH-1:0]  r_conflict_cnt;

    logic                  w_idle;
    logic                  w_busy;
    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_hit;
    logic                  w_tmo;
    logic                  w_done;
    logic                  w_conflict;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_busy    = ~w_idle;
    assign w_grant_d = w_idle & dm_req;
    assign w_grant_i = w_idle & ~dm_req & if_req;
    // A ready arriving in the timeout cycle wins, so the abort needs ~mem_ready.
    assign w_hit     = w_busy & mem_ready;
    assign w_tmo     = (TIMEOUT != 0) & w_busy & ~mem_ready & (r_tmo_cnt == TMO_LAST);
    assign w_done    = w_hit | w_tmo;
    // IF is blocked whenever data traffic holds or is about to take the port.
    assign w_conflict = if_req & ((r_state == ST_SERVE_D) | (w_idle & dm_req));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: data first from IDLE, return to IDLE when the access ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dm_req) begin
                    w_state_nxt = ST_SERVE_D;
                end else if (if_req) begin
                    w_state_nxt = ST_SERVE_I;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-port acks and read data; everything is zero unless that port completes.
    always_comb begin
        if_ack   = 1'b0;
        dm_ack   = 1'b0;
        if_rdata = '0;
        dm_rdata = '0;
        bus_err  = w_tmo;
        if (r_state == ST_SERVE_I) begin
            if_ack = w_done;
            if (w_hit) begin
                if_rdata = mem_rdata;
            end
        end
        if (r_state == ST_SERVE_D) begin
            dm_ack = w_done;
            if (w_hit) begin
                dm_rdata = mem_rdata;
            end
        end
    end

    // Memory request registers: captured at grant, held until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_mask  <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else if (w_grant_d) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_mask  <= dm_mask;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
        end else if (w_grant_i) begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_mask  <= 4'hF;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= 32'h0;
        end else if (w_done) begin
            r_mem_valid <= 1'b0;
        end
    end

    // Wait-cycle counter for the access in flight; frozen when timeout is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_idle || w_done) begin
            r_tmo_cnt <= '0;
        end else if (TIMEOUT != 0) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // Saturating count of cycles in which IF lost the port to data traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (perf_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && !(&r_conflict_cnt)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
        end
    end

    assign mem_valid    = r_mem_valid;
    assign mem_we       = r_mem_we;
    assign mem_mask     = r_mem_mask;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign stall_if     = if_req & ~if_ack;
    assign stall_mem    = dm_req & ~dm_ack;
    assign conflict_cnt = r_conflict_cnt;
    assign dbg_state    = r_state;

endmodule
